// File: rtl/dff_rst_gen_if.sv
// Reset generator status/request bundle: soft reset request in,
// sequenced active-low domain resets and status out.
//   master (generator): sw_rst_req in; rstn_out, rst_done, busy out
//   slave  (consumer) : sw_rst_req out; rstn_out, rst_done, busy in
interface dff_rst_gen_if #(
    parameter int NUM_OUT = 4
);
    logic               sw_rst_req;
    logic [NUM_OUT-1:0] rstn_out;
    logic               rst_done;
    logic               busy;

    modport master (
        input  sw_rst_req,
        output rstn_out,
        output rst_done,
        output busy
    );

    modport slave (
        output sw_rst_req,
        input  rstn_out,
        input  rst_done,
        input  busy
    );
endinterface

// File: rtl/dff_rst_gen.sv
// Reset generator: async-assert, sync staggered-release domain resets.
// Ports: clk, rstn (async active-low), rst_if (master): sw_rst_req in;
//        rstn_out[NUM_OUT], rst_done, busy out (all registered).
module dff_rst_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4,
    parameter int NUM_OUT     = 4
) (
    input  logic          clk,
    input  logic          rstn,
    dff_rst_gen_if.master rst_if
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        SYNC,
        HOLD,
        RELEASE,
        RUN
    } state_t;

    // Deassertion synchronizer; kept as discrete flops so the
    // metastability chain is never retimed or merged.
    (* async_reg = "true", dont_touch = "true" *)
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rstn_sync;

    state_t             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SW-1:0]      step_q, step_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_OUT-1:0] ro_q, ro_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rstn_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SYNC;
            hold_q  <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            ro_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            ro_q    <= ro_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        step_d  = step_q;
        idx_d   = idx_q;
        ro_d    = ro_q;

        unique case (state_q)
            SYNC: begin
                if (rstn_sync) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    ro_d[0] = 1'b1;
                    if (NUM_OUT == 1) begin
                        state_d = RUN;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IW'(1);
                        step_d  = STEP_LOAD;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            RELEASE: begin
                if (step_q == '0) begin
                    ro_d[idx_q] = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        step_d = STEP_LOAD;
                    end
                end else begin
                    step_d = step_q - 1'b1;
                end
            end
            RUN: begin
                ro_d = '1;
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        // Soft reset wins over any release due on the same edge.
        if (state_q != SYNC && rst_if.sw_rst_req) begin
            ro_d    = '0;
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
            idx_d   = '0;
        end

        done_d = (state_d == RUN);
        busy_d = (state_d != RUN);
    end

    assign rst_if.rstn_out = ro_q;
    assign rst_if.rst_done = done_q;
    assign rst_if.busy     = busy_q;
endmodule

// File: tb/tb_dff_rst_gen.sv
// Directed bench for dff_rst_gen: default instance plus a
// NUM_OUT=1/HOLD_CYCLES=1 instance sharing clk and rstn.
module tb_dff_rst_gen;
    localparam int S = 2;
    localparam int H = 16;
    localparam int P = 4;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] ro;
        logic         done;
        logic         busy;
        logic         ro1;
        logic         done1;
        logic         busy1;
    } exp_t;

    logic clk;
    logic rstn;

    int   checks;
    int   errors;
    int   e;
    int   t0;
    exp_t q[$];

    dff_rst_gen_if #(.NUM_OUT(N)) ifa ();
    dff_rst_gen_if #(.NUM_OUT(1)) ifb ();

    dff_rst_gen #(
        .SYNC_STAGES(S),
        .HOLD_CYCLES(H),
        .STEP_CYCLES(P),
        .NUM_OUT(N)
    ) dut_a (
        .clk   (clk),
        .rstn  (rstn),
        .rst_if(ifa.master)
    );

    dff_rst_gen #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(1),
        .STEP_CYCLES(4),
        .NUM_OUT(1)
    ) dut_b (
        .clk   (clk),
        .rstn  (rstn),
        .rst_if(ifb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after edge ed, from the documented release times.
    function automatic exp_t model(input int ed);
        exp_t x;
        for (int i = 0; i < N; i++) begin
            x.ro[i] = (ed >= t0 + H + i * P);
        end
        x.done  = (ed >= t0 + H + (N - 1) * P);
        x.busy  = !x.done;
        x.ro1   = (ed >= 4);
        x.done1 = (ed >= 4);
        x.busy1 = (ed < 4);
        return x;
    endfunction

    task automatic check(input string tag);
        exp_t x;
        x = q.pop_front();
        checks++;
        assert (ifa.rstn_out === x.ro) else begin
            errors++;
            $error("FAIL %s e=%0d rstn_out got %b exp %b",
                   tag, e, ifa.rstn_out, x.ro);
        end
        checks++;
        assert (ifa.rst_done === x.done) else begin
            errors++;
            $error("FAIL %s e=%0d rst_done got %b exp %b",
                   tag, e, ifa.rst_done, x.done);
        end
        checks++;
        assert (ifa.busy === x.busy) else begin
            errors++;
            $error("FAIL %s e=%0d busy got %b exp %b",
                   tag, e, ifa.busy, x.busy);
        end
        checks++;
        assert (ifb.rstn_out[0] === x.ro1) else begin
            errors++;
            $error("FAIL %s_n1 e=%0d rstn_out got %b exp %b",
                   tag, e, ifb.rstn_out[0], x.ro1);
        end
        checks++;
        assert (ifb.rst_done === x.done1) else begin
            errors++;
            $error("FAIL %s_n1 e=%0d rst_done got %b exp %b",
                   tag, e, ifb.rst_done, x.done1);
        end
        checks++;
        assert (ifb.busy === x.busy1) else begin
            errors++;
            $error("FAIL %s_n1 e=%0d busy got %b exp %b",
                   tag, e, ifb.busy, x.busy1);
        end
    endtask

    task automatic chk_reset(input string tag);
        exp_t x;
        x.ro    = '0;
        x.done  = 1'b0;
        x.busy  = 1'b1;
        x.ro1   = 1'b0;
        x.done1 = 1'b0;
        x.busy1 = 1'b1;
        q.push_back(x);
        check(tag);
    endtask

    // One clock edge with sw_rst_req driven to sw.
    task automatic tick(input logic sw, input string tag);
        ifa.sw_rst_req = sw;
        e++;
        if (sw && e >= S + 2) t0 = e;
        q.push_back(model(e));
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Release rstn half a cycle before the next edge (called at posedge+1).
    task automatic release_rstn();
        #4;
        rstn = 1'b1;
        e    = 0;
        t0   = S + 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        e      = 0;
        t0     = S + 1;
        rstn   = 1'b0;
        ifa.sw_rst_req = 1'b0;
        ifb.sw_rst_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");

        // Power-on sequence; sw during SYNC is ignored; soft reset at 50.
        release_rstn();
        tick(1'b1, "sync_sw");
        tick(1'b1, "sync_sw");
        while (e < 49) tick(1'b0, "boot");
        tick(1'b1, "soft50");
        while (e < 80) tick(1'b0, "rerel");

        // Soft reset held over edges 40..45.
        rstn = 1'b0;
        #1;
        chk_reset("rst2");
        @(posedge clk);
        #1;
        release_rstn();
        while (e < 39) tick(1'b0, "boot2");
        while (e < 45) tick(1'b1, "held");
        while (e < 75) tick(1'b0, "after_held");

        // Async assert mid-RELEASE, between edges.
        rstn = 1'b0;
        #1;
        chk_reset("rst3");
        @(posedge clk);
        #1;
        release_rstn();
        while (e < 24) tick(1'b0, "boot3");
        #3;
        rstn = 1'b0;
        #1;
        chk_reset("async_mid");
        repeat (2) @(posedge clk);
        #1;
        chk_reset("held_low");
        release_rstn();
        while (e < 35) tick(1'b0, "reboot");

        // Sub-cycle glitch in RUN restarts the full sequence.
        #2;
        rstn = 1'b0;
        #1;
        chk_reset("glitch");
        #1;
        rstn = 1'b1;
        e    = 0;
        t0   = S + 1;
        while (e < 35) tick(1'b0, "post_glitch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
